// File: rtl/baud_gen_multi.sv
// Multi-rate UART baud tick generator with frame bit counter.
// Runtime rate select, mid-bit (RX) or bit-end (TX) ticks, busy/done handshake with abort.
//
// state  | meaning
// S_IDLE | no frame; cnt and bit_idx held at 0, start (with legal divisor) accepted
// S_RUN  | frame in progress; cnt counts bit period, bit_idx counts periods
module baud_gen_multi #(
    parameter int CLK_HZ     = 50000000,
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = 10,
    parameter int MIN_DIV    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       baud_sel,
    input  logic [CNT_W-1:0] div_custom,
    input  logic             mid_sample,
    output logic             clk_bps,
    output logic [3:0]       bit_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_HZ / 9600   - 1);
    localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_HZ / 19200  - 1);
    localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_HZ / 38400  - 1);
    localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_HZ / 57600  - 1);
    localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_HZ / 115200 - 1);
    localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt, div_q, half_q, div_sel, tick_pt;
    logic             mode_q;
    logic             legal, accept, reject, wrap, frame_end, tick_hit;
    logic             done_d, bps_d, err_d;

    always_comb begin
        div_sel = div_custom;
        case (baud_sel)
            3'd0:    div_sel = DIV_9600;
            3'd1:    div_sel = DIV_19200;
            3'd2:    div_sel = DIV_38400;
            3'd3:    div_sel = DIV_57600;
            3'd4:    div_sel = DIV_115200;
            default: div_sel = div_custom;
        endcase
    end

    assign legal     = (baud_sel < 3'd5) || (div_custom >= CNT_W'(MIN_DIV));
    assign accept    = (state_q == S_IDLE) && start && !abort && legal;
    assign reject    = (state_q == S_IDLE) && start && !abort && !legal;
    assign wrap      = (cnt == div_q);
    assign frame_end = (state_q == S_RUN) && wrap && (bit_idx == LAST_BIT);
    assign tick_pt   = mode_q ? half_q : div_q;
    assign tick_hit  = (state_q == S_RUN) && (cnt == tick_pt);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (abort || frame_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Abort suppresses every pulse due on the same edge, including the final done.
    always_comb begin
        busy   = (state_q == S_RUN);
        done_d = frame_end && !abort;
        bps_d  = tick_hit && !abort;
        err_d  = reject;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
            clk_bps <= 1'b0;
            cfg_err <= 1'b0;
            div_q   <= '0;
            half_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            done    <= done_d;
            clk_bps <= bps_d;
            cfg_err <= err_d;
            if (accept) begin
                div_q   <= div_sel;
                half_q  <= div_sel >> 1;
                mode_q  <= mid_sample;
                cnt     <= '0;
                bit_idx <= '0;
            end else if (state_q == S_RUN && !abort && !frame_end) begin
                if (wrap) begin
                    cnt     <= '0;
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt     <= '0;
                bit_idx <= '0;
            end
        end
    end

endmodule
